// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered N_IN:1 mux of W-bit channels with manual select or dwell-timed auto-scan.
// Define MUX_SCAN_MASK_EN to add a ch_mask port that restricts which channels the scan visits.
module mux_scan_reg #(
    parameter  int N_IN  = 8,
    parameter  int W     = 1,
    parameter  int DWELL = 1,
    localparam int SW    = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN*W-1:0] in,
    input  logic [SW-1:0]     sel,
    input  logic              mode,
    input  logic              en,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N_IN-1:0]   ch_mask,
`endif
    output logic [W-1:0]      out,
    output logic              out_valid,
    output logic [SW-1:0]     cur_sel,
    output logic              scan_wrap,
    output logic              sel_err
);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [W-1:0]  chans [N_IN];
    logic [SW-1:0] scan_idx, idx_d, eff_idx, nxt_idx, cur_d;
    logic [DW-1:0] dwell_cnt, cnt_d, eff_cnt;
    logic          mode_q, mode_d, mode_rise, nxt_wrap, dwell_last;
    logic [W-1:0]  out_d;
    logic          valid_d, wrap_d, err_d;

    for (genvar g = 0; g < N_IN; g++) begin : g_chan
        assign chans[g] = in[g*W +: W];
    end

    // Entering scan mode restarts at channel 0 on that very edge, so the
    // first scan edge outputs channel 0 and then advances normally.
    assign mode_rise  = mode && !mode_q;
    assign eff_idx    = mode_rise ? '0 : scan_idx;
    assign eff_cnt    = mode_rise ? '0 : dwell_cnt;
    assign dwell_last = (eff_cnt == DW'(DWELL - 1));

`ifdef MUX_SCAN_MASK_EN
    int            cand;
    logic          found;
    logic [SW-1:0] cidx;

    always_comb begin
        nxt_idx  = eff_idx;
        nxt_wrap = 1'b0;
        found    = 1'b0;
        cand     = 0;
        cidx     = '0;
        for (int k = 1; k <= N_IN; k++) begin
            cand = int'(eff_idx) + k;
            cidx = SW'(cand % N_IN);
            if (!found && ch_mask[cidx]) begin
                found    = 1'b1;
                nxt_idx  = cidx;
                nxt_wrap = (cand >= N_IN);
            end
        end
    end
`else
    always_comb begin
        nxt_idx  = eff_idx + 1'b1;
        nxt_wrap = 1'b0;
        if (int'(eff_idx) == N_IN - 1) begin
            nxt_idx  = '0;
            nxt_wrap = 1'b1;
        end
    end
`endif

    // NOTE: every signal gets a default at the top of always_comb, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        out_d   = out;
        valid_d = 1'b0;
        cur_d   = cur_sel;
        wrap_d  = 1'b0;
        err_d   = sel_err;
        idx_d   = scan_idx;
        cnt_d   = dwell_cnt;
        mode_d  = mode_q;
        if (en) begin
            mode_d = mode;
            if (!mode) begin
                valid_d = 1'b1;
                cur_d   = sel;
                if (int'(sel) < N_IN) begin
                    out_d = chans[sel];
                    err_d = 1'b0;
                end else begin
                    out_d = '0;
                    err_d = 1'b1;
                end
            end else begin
                err_d = 1'b0;
`ifdef MUX_SCAN_MASK_EN
                if (ch_mask == '0) begin
                    out_d = '0;
                end else if (!ch_mask[eff_idx]) begin
                    // Masked position: move on without presenting it.
                    idx_d  = nxt_idx;
                    cnt_d  = '0;
                    wrap_d = nxt_wrap;
                end else
`endif
                begin
                    out_d   = chans[eff_idx];
                    cur_d   = eff_idx;
                    valid_d = 1'b1;
                    if (dwell_last) begin
                        cnt_d  = '0;
                        idx_d  = nxt_idx;
                        wrap_d = nxt_wrap;
                    end else begin
                        cnt_d  = eff_cnt + 1'b1;
                        idx_d  = eff_idx;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            cur_sel   <= '0;
            scan_wrap <= 1'b0;
            sel_err   <= 1'b0;
            scan_idx  <= '0;
            dwell_cnt <= '0;
            mode_q    <= 1'b0;
        end else begin
            out       <= out_d;
            out_valid <= valid_d;
            cur_sel   <= cur_d;
            scan_wrap <= wrap_d;
            sel_err   <= err_d;
            scan_idx  <= idx_d;
            dwell_cnt <= cnt_d;
            mode_q    <= mode_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: directed, table-driven bench for mux_scan_reg across three parameter sets.
// With MUX_SCAN_MASK_EN defined it also runs a short masked-scan sequence.
module tb_mux_scan_reg;
    logic        clk;
    logic        rst_n;
    logic        en, mode;
    logic [2:0]  sel;
    logic [11:0] din;

    logic       o8, v8, w8, e8;
    logic [2:0] cs8;
    logic       o3, v3, w3, e3;
    logic [2:0] cs3;
    logic [1:0] o6;
    logic       v6, w6, e6;
    logic [2:0] cs6;

`ifdef MUX_SCAN_MASK_EN
    logic [7:0] ch_mask;
    logic [5:0] ch_mask6;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic       mode;
        logic [2:0] sel;
        logic [11:0] din;
        logic [1:0] e_out;
        logic       e_valid;
        logic [2:0] e_cur;
        logic       e_wrap;
        logic       e_err;
    } vec_t;

    vec_t main_q[$];
    vec_t post_q[$];
    vec_t d3_q[$];
    vec_t n6_q[$];
    vec_t mask_q[$];

    mux_scan_reg #(.N_IN(8), .W(1), .DWELL(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in(din[7:0]), .sel(sel), .mode(mode), .en(en),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(ch_mask),
`endif
        .out(o8), .out_valid(v8), .cur_sel(cs8), .scan_wrap(w8), .sel_err(e8)
    );

    mux_scan_reg #(.N_IN(8), .W(1), .DWELL(3)) dut_d3 (
        .clk(clk), .rst_n(rst_n), .in(din[7:0]), .sel(sel), .mode(mode), .en(en),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(ch_mask),
`endif
        .out(o3), .out_valid(v3), .cur_sel(cs3), .scan_wrap(w3), .sel_err(e3)
    );

    mux_scan_reg #(.N_IN(6), .W(2), .DWELL(1)) dut6 (
        .clk(clk), .rst_n(rst_n), .in(din), .sel(sel), .mode(mode), .en(en),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(ch_mask6),
`endif
        .out(o6), .out_valid(v6), .cur_sel(cs6), .scan_wrap(w6), .sel_err(e6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic a_en, logic a_mode, logic [2:0] a_sel, logic [11:0] a_din,
                                logic [1:0] x_out, logic x_valid, logic [2:0] x_cur,
                                logic x_wrap, logic x_err);
        vec_t r;
        r.en = a_en; r.mode = a_mode; r.sel = a_sel; r.din = a_din;
        r.e_out = x_out; r.e_valid = x_valid; r.e_cur = x_cur;
        r.e_wrap = x_wrap; r.e_err = x_err;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample(input int which, output logic [1:0] a_out, output logic a_valid,
                          output logic [2:0] a_cur, output logic a_wrap, output logic a_err);
        case (which)
            0:       begin a_out = {1'b0, o8}; a_valid = v8; a_cur = cs8; a_wrap = w8; a_err = e8; end
            1:       begin a_out = {1'b0, o3}; a_valid = v3; a_cur = cs3; a_wrap = w3; a_err = e3; end
            default: begin a_out = o6;         a_valid = v6; a_cur = cs6; a_wrap = w6; a_err = e6; end
        endcase
    endtask

    task automatic run_vec(input vec_t t, input int which, input string tag, input int idx);
        logic [1:0] a_out;
        logic       a_valid, a_wrap, a_err;
        logic [2:0] a_cur;
        en = t.en; mode = t.mode; sel = t.sel; din = t.din;
        @(posedge clk);
        #1;
        sample(which, a_out, a_valid, a_cur, a_wrap, a_err);
        check($sformatf("%s[%0d].out", tag, idx), 32'(a_out), 32'(t.e_out));
        check($sformatf("%s[%0d].valid", tag, idx), 32'(a_valid), 32'(t.e_valid));
        check($sformatf("%s[%0d].cur_sel", tag, idx), 32'(a_cur), 32'(t.e_cur));
        check($sformatf("%s[%0d].wrap", tag, idx), 32'(a_wrap), 32'(t.e_wrap));
        check($sformatf("%s[%0d].sel_err", tag, idx), 32'(a_err), 32'(t.e_err));
    endtask

    // Assert reset between edges, check the async clear, hold it across one edge, release off-edge.
    task automatic do_reset(input int which, input string tag);
        logic [1:0] a_out;
        logic       a_valid, a_wrap, a_err;
        logic [2:0] a_cur;
        rst_n = 1'b0;
        #1;
        sample(which, a_out, a_valid, a_cur, a_wrap, a_err);
        check({tag, ".rst_out"}, 32'(a_out), 32'd0);
        check({tag, ".rst_valid"}, 32'(a_valid), 32'd0);
        check({tag, ".rst_cur_sel"}, 32'(a_cur), 32'd0);
        check({tag, ".rst_wrap"}, 32'(a_wrap), 32'd0);
        check({tag, ".rst_sel_err"}, 32'(a_err), 32'd0);
        #12;
        rst_n = 1'b1;
    endtask

    initial begin
        // Manual then scan on N_IN=8, DWELL=1.
        main_q.push_back(mk(1, 0, 1, 12'h002, 1, 1, 1, 0, 0));
        main_q.push_back(mk(1, 0, 1, 12'h020, 0, 1, 1, 0, 0));
        main_q.push_back(mk(1, 0, 7, 12'h080, 1, 1, 7, 0, 0));
        main_q.push_back(mk(0, 0, 3, 12'h0FF, 1, 0, 7, 0, 0));
        main_q.push_back(mk(1, 1, 0, 12'h0A5, 1, 1, 0, 0, 0));
        main_q.push_back(mk(1, 1, 0, 12'h0A5, 0, 1, 1, 0, 0));
        main_q.push_back(mk(1, 1, 0, 12'h0A5, 1, 1, 2, 0, 0));
        main_q.push_back(mk(1, 1, 0, 12'h0A5, 0, 1, 3, 0, 0));
        main_q.push_back(mk(1, 1, 0, 12'h0A5, 0, 1, 4, 0, 0));
        main_q.push_back(mk(1, 1, 0, 12'h0A5, 1, 1, 5, 0, 0));
        main_q.push_back(mk(1, 1, 0, 12'h0A5, 0, 1, 6, 0, 0));
        main_q.push_back(mk(1, 1, 0, 12'h0A5, 1, 1, 7, 1, 0));
        main_q.push_back(mk(1, 1, 0, 12'h0A5, 1, 1, 0, 0, 0));
        main_q.push_back(mk(1, 1, 0, 12'h0A5, 0, 1, 1, 0, 0));
        main_q.push_back(mk(0, 1, 0, 12'h0A5, 0, 0, 1, 0, 0));
        main_q.push_back(mk(1, 1, 0, 12'h0A5, 1, 1, 2, 0, 0));
        main_q.push_back(mk(1, 0, 4, 12'h010, 1, 1, 4, 0, 0));
        main_q.push_back(mk(1, 1, 0, 12'h0A5, 1, 1, 0, 0, 0));
        main_q.push_back(mk(1, 1, 0, 12'h0A5, 0, 1, 1, 0, 0));
        main_q.push_back(mk(1, 1, 0, 12'h0A5, 1, 1, 2, 0, 0));

        post_q.push_back(mk(1, 1, 0, 12'h0A5, 1, 1, 0, 0, 0));
        post_q.push_back(mk(1, 1, 0, 12'h0A5, 0, 1, 1, 0, 0));

        // DWELL=3: three edges per channel, en gaps hold, data tracked within a dwell.
        for (int i = 0; i < 3; i++) d3_q.push_back(mk(1, 1, 0, 12'h00C, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) d3_q.push_back(mk(1, 1, 0, 12'h00C, 0, 1, 1, 0, 0));
        d3_q.push_back(mk(1, 1, 0, 12'h00C, 1, 1, 2, 0, 0));
        d3_q.push_back(mk(0, 1, 0, 12'h00C, 1, 0, 2, 0, 0));
        d3_q.push_back(mk(0, 1, 0, 12'h00C, 1, 0, 2, 0, 0));
        d3_q.push_back(mk(1, 1, 0, 12'h00C, 1, 1, 2, 0, 0));
        d3_q.push_back(mk(1, 1, 0, 12'h00C, 1, 1, 2, 0, 0));
        d3_q.push_back(mk(1, 1, 0, 12'h00C, 1, 1, 3, 0, 0));
        d3_q.push_back(mk(1, 1, 0, 12'h004, 0, 1, 3, 0, 0));
        d3_q.push_back(mk(1, 1, 0, 12'h00C, 1, 1, 3, 0, 0));
        for (int ch = 4; ch < 8; ch++)
            for (int d = 0; d < 3; d++)
                d3_q.push_back(mk(1, 1, 0, 12'h00C, 0, 1, 3'(ch), (ch == 7 && d == 2), 0));
        d3_q.push_back(mk(1, 1, 0, 12'h00C, 0, 1, 0, 0, 0));

        // N_IN=6, W=2: out-of-range select and a 6-channel scan.
        n6_q.push_back(mk(1, 0, 7, 12'h000, 0, 1, 7, 0, 1));
        n6_q.push_back(mk(1, 0, 5, 12'hC00, 3, 1, 5, 0, 0));
        n6_q.push_back(mk(1, 0, 2, 12'h020, 2, 1, 2, 0, 0));
        n6_q.push_back(mk(1, 0, 6, 12'hFFF, 0, 1, 6, 0, 1));
        n6_q.push_back(mk(0, 0, 1, 12'hFFF, 0, 0, 6, 0, 1));
        n6_q.push_back(mk(1, 1, 0, 12'h939, 1, 1, 0, 0, 0));
        n6_q.push_back(mk(1, 1, 0, 12'h939, 2, 1, 1, 0, 0));
        n6_q.push_back(mk(1, 1, 0, 12'h939, 3, 1, 2, 0, 0));
        n6_q.push_back(mk(1, 1, 0, 12'h939, 0, 1, 3, 0, 0));
        n6_q.push_back(mk(1, 1, 0, 12'h939, 1, 1, 4, 0, 0));
        n6_q.push_back(mk(1, 1, 0, 12'h939, 2, 1, 5, 1, 0));
        n6_q.push_back(mk(1, 1, 0, 12'h939, 1, 1, 0, 0, 0));

        // Masked scan with ch_mask=8'h85: visits 0,2,7,0.
        mask_q.push_back(mk(1, 1, 0, 12'h0A5, 1, 1, 0, 0, 0));
        mask_q.push_back(mk(1, 1, 0, 12'h0A5, 1, 1, 2, 0, 0));
        mask_q.push_back(mk(1, 1, 0, 12'h0A5, 1, 1, 7, 1, 0));
        mask_q.push_back(mk(1, 1, 0, 12'h0A5, 1, 1, 0, 0, 0));

        en = 1'b0; mode = 1'b0; sel = '0; din = '0;
`ifdef MUX_SCAN_MASK_EN
        ch_mask  = 8'hFF;
        ch_mask6 = 6'h3F;
`endif
        rst_n = 1'b0;
        #2;
        check("init.out8", 32'(o8), 32'd0);
        check("init.valid8", 32'(v8), 32'd0);
        check("init.cur8", 32'(cs8), 32'd0);
        check("init.out6", 32'(o6), 32'd0);
        check("init.err6", 32'(e6), 32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (main_q[i]) run_vec(main_q[i], 0, "main", i);
        do_reset(0, "mid_scan");
        foreach (post_q[i]) run_vec(post_q[i], 0, "post_rst", i);

        do_reset(1, "d3");
        foreach (d3_q[i]) run_vec(d3_q[i], 1, "dwell3", i);

        do_reset(2, "n6");
        foreach (n6_q[i]) run_vec(n6_q[i], 2, "n6", i);

`ifdef MUX_SCAN_MASK_EN
        do_reset(0, "mask");
        ch_mask = 8'h85;
        foreach (mask_q[i]) run_vec(mask_q[i], 0, "mask", i);
        ch_mask = 8'h00;
        run_vec(mk(1, 1, 0, 12'h0A5, 0, 0, 0, 0, 0), 0, "mask_zero", 0);
        ch_mask = 8'h80;
        run_vec(mk(1, 1, 0, 12'h0A5, 0, 0, 0, 0, 0), 0, "mask_skip", 0);
        run_vec(mk(1, 1, 0, 12'h0A5, 1, 1, 7, 1, 0), 0, "mask_skip", 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
